load_store_unit: RTL and testbench

- Sits directly upstream of the unified word memory, on its data port (line / write_data / write / data).
- Converts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-line memory accesses.
- Sub-word stores use a read-modify-write sequence.
- Returns sign- or zero-extended load data to the execute stage through a valid/ready request and single-cycle response handshake.

---
 rtl/load_store_unit.sv | 91 +++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores onto a word-line memory; LSU_RANGE_CHECK_EN faults out-of-range addresses
module load_store_unit #(
  parameter int LINE_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [LINE_W-1:0] mem_line,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  input  logic [31:0]       mem_data
);
  typedef enum logic [2:0] {IDLE, RD, WR, RESP, FAULT} state_t;
  state_t            state, state_n;
  logic [LINE_W+1:0] addr_q;
  logic [31:0]       wdata_q, word_q, mask, merged, load_val;
  logic [1:0]        size_q;
  logic              we_q, uns_q, accept, bad, out_of_range;
  logic [4:0]        sh;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  assign accept = req_valid && state == IDLE;
`ifdef LSU_RANGE_CHECK_EN
  assign out_of_range = |req_addr[31:LINE_W+2];
`else
  logic unused_hi;
  assign unused_hi = |req_addr[31:LINE_W+2];
  assign out_of_range = 1'b0;
`endif
  assign bad = out_of_range || req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'd0);
  // lane shift/mask for the registered access: merge for stores, extract for loads
  always_comb begin
    sh       = size_q == 2'd0 ? {addr_q[1:0], 3'b000} : size_q == 2'd1 ? {addr_q[1], 4'b0000} : 5'd0;
    mask     = size_q == 2'd0 ? 32'h0000_00ff << sh : size_q == 2'd1 ? 32'h0000_ffff << sh : 32'hffff_ffff;
    merged   = (word_q & ~mask) | ((wdata_q << sh) & mask);
    byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = word_q[{addr_q[1], 4'b0000} +: 16];
    load_val = size_q == 2'd0 ? {{24{~uns_q & byte_sel[7]}}, byte_sel} :
               size_q == 2'd1 ? {{16{~uns_q & half_sel[15]}}, half_sel} : word_q;
  end
  // state register; reset aborts any in-flight access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  // request capture at acceptance and read word capture in RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr[LINE_W+1:0];
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
      end
      if (state == RD) word_q <= mem_data;
    end
  end
  // next state and state-decoded outputs
  always_comb begin
    state_n        = IDLE;
    req_ready      = state == IDLE;
    resp_valid     = state == RESP || state == FAULT;
    resp_fault     = state == FAULT;
    resp_rdata     = (state == RESP && !we_q) ? load_val : 32'd0;
    mem_write      = state == WR;
    mem_line       = (state == RD || state == WR) ? addr_q[LINE_W+1:2] : '0;
    mem_write_data = state == WR ? merged : 32'd0;
    state_n        = state == IDLE ? (!accept ? IDLE : bad ? FAULT :
                                      (req_we && req_size == 2'd2) ? WR : RD) :
                     state == RD   ? (we_q ? WR : RESP) :
                     state == WR   ? RESP : IDLE;
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven and randomized checks of load_store_unit against a byte-array memory model
module tb_load_store_unit;
  logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, clr = 1'b1;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_fault, mem_write;
  logic [31:0] resp_rdata, mem_write_data, mem_data;
  logic [11:0] mem_line;
`ifdef LSU_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  load_store_unit #(.LINE_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_line(mem_line), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  assign mem_data = mem[mem_line];
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 4096; i++) mem[i] <= 32'd0;
    else if (mem_write) mem[mem_line] <= mem_write_data;
  end

  int          wr_cnt = 0;
  logic [11:0] last_line = 12'd0;
  always @(negedge clk) if (mem_write) begin wr_cnt++; last_line = mem_line; end

  int vectors = 0, miscompares = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [7:0] ref_b [0:16383];
  task automatic model(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic f, output int lat);
    int nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    int base = int'(a % 32'd16384);
    f  = (sz == 2'd3) || (a % nb != 0) || (RC && a >= 32'h4000);
    rd = 32'd0;
    if (f) lat = 1;
    else if (we) begin
      for (int i = 0; i < nb; i++) ref_b[base+i] = wd[8*i +: 8];
      lat = (nb == 4) ? 2 : 3;
    end else begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_b[base+i];
      if (!u && nb < 4 && rd[8*nb-1]) rd = rd | (32'hffff_ffff << (8*nb));
      lat = 2;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic f,
                        output int lat, output int wr, output logic [11:0] ln);
    int w0;
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    w0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    rd = resp_rdata; f = resp_fault; wr = wr_cnt - w0; ln = last_line;
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
  endtask

  task automatic run(input string nm, input logic we, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input logic ef, input int elat);
    logic [31:0] rd;
    logic        f;
    int          lat, wr;
    logic [11:0] ln;
    do_req(we, sz, u, a, wd, rd, f, lat, wr, ln);
    chk({nm, "_rdata"}, rd, erd);
    chk({nm, "_fault"}, 32'(f), 32'(ef));
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_writes"}, 32'(wr), 32'(we && !ef));
    if (we && !ef) chk({nm, "_line"}, 32'(ln), (a >> 2) & 32'hfff);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    logic        fault;
    int          lat;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic [31:0] erd, bexp[3];
    logic        ef;
    int          elat, nacc, nresp;
    logic [31:0] ba[3];
    logic [1:0]  bs[3];
    for (int i = 0; i < 16384; i++) ref_b[i] = 8'd0;
    tbl.push_back('{1, 2'd2, 0, 32'h10, 32'hdeadbeef, 32'h0, 0, 2});
    tbl.push_back('{0, 2'd2, 0, 32'h10, 32'h0, 32'hdeadbeef, 0, 2});
    tbl.push_back('{1, 2'd0, 0, 32'h11, 32'h80, 32'h0, 0, 3});
    tbl.push_back('{0, 2'd2, 0, 32'h10, 32'h0, 32'hdead80ef, 0, 2});
    tbl.push_back('{0, 2'd0, 0, 32'h11, 32'h0, 32'hffffff80, 0, 2});
    tbl.push_back('{0, 2'd0, 1, 32'h11, 32'h0, 32'h00000080, 0, 2});
    tbl.push_back('{1, 2'd1, 0, 32'h12, 32'h1234, 32'h0, 0, 3});
    tbl.push_back('{0, 2'd1, 0, 32'h12, 32'h0, 32'h00001234, 0, 2});
    tbl.push_back('{0, 2'd2, 0, 32'h10, 32'h0, 32'h123480ef, 0, 2});
    tbl.push_back('{0, 2'd1, 0, 32'h13, 32'h0, 32'h0, 1, 1});
    tbl.push_back('{0, 2'd2, 0, 32'h0e, 32'h0, 32'h0, 1, 1});
    tbl.push_back('{0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1, 1});
    tbl.push_back('{1, 2'd1, 0, 32'h11, 32'hffff, 32'h0, 1, 1});
    tbl.push_back('{0, 2'd1, 0, 32'h10, 32'h0, 32'hffff80ef, 0, 2});
    tbl.push_back('{0, 2'd1, 1, 32'h10, 32'h0, 32'h000080ef, 0, 2});
    tbl.push_back('{1, 2'd0, 0, 32'h13, 32'hffffffa5, 32'h0, 0, 3});
    tbl.push_back('{0, 2'd2, 0, 32'h10, 32'h0, 32'ha53480ef, 0, 2});
    tbl.push_back('{0, 2'd1, 0, 32'h12, 32'h0, 32'hffffa534, 0, 2});
    tbl.push_back('{0, 2'd0, 0, 32'h10, 32'h0, 32'hffffffef, 0, 2});
    tbl.push_back('{0, 2'd2, 0, 32'h4010, 32'h0, RC ? 32'h0 : 32'ha53480ef, RC, RC ? 1 : 2});
    tbl.push_back('{0, 2'd2, 0, 32'h10000, 32'h0, 32'h0, RC, RC ? 1 : 2});
    tbl.push_back('{1, 2'd2, 0, 32'h14000, 32'h11111111, 32'h0, RC, RC ? 1 : 2});
    tbl.push_back('{0, 2'd2, 0, 32'h0, 32'h0, RC ? 32'h0 : 32'h11111111, 0, 2});

    repeat (3) @(posedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fault", 32'(resp_fault), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_line", 32'(mem_line), 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[k]) begin
      model(tbl[k].we, tbl[k].size, tbl[k].uns, tbl[k].addr, tbl[k].wdata, erd, ef, elat);
      run($sformatf("tbl%0d", k), tbl[k].we, tbl[k].size, tbl[k].uns, tbl[k].addr, tbl[k].wdata,
          tbl[k].rdata, tbl[k].fault, tbl[k].lat);
    end

    model(1, 2'd2, 0, 32'h20, 32'hcafef00d, erd, ef, elat);
    run("pre_abort_sw", 1, 2'd2, 0, 32'h20, 32'hcafef00d, 32'h0, 0, 2);
    for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wr", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_write_drop", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_no_resp", 32'(resp_valid), 32'd0);
    chk("abort_mem_word", mem[8], 32'hcafef00d);
    run("post_abort_lw", 0, 2'd2, 0, 32'h20, 32'h0, 32'hcafef00d, 0, 2);

    ba = '{32'h10, 32'h20, 32'h12};
    bs = '{2'd2, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) model(0, bs[i], 0, ba[i], 32'h0, bexp[i], ef, elat);
    nacc = 0; nresp = 0;
    @(negedge clk);
    for (int c = 0; c < 40 && nresp < 3; c++) begin
      if (resp_valid) begin
        chk($sformatf("b2b_data%0d", nresp), resp_rdata, bexp[nresp]);
        nresp++;
      end
      if (req_ready) begin
        if (nacc < 3) begin
          req_valid = 1'b1; req_we = 1'b0; req_unsigned = 1'b0;
          req_addr = ba[nacc]; req_size = bs[nacc];
          nacc++;
        end else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_count", 32'(nresp), 32'd3);
    @(negedge clk);

    for (int k = 0; k < 80; k++) begin
      logic        we, u;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      we = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) a = a | ($urandom << 14);
      wd = $urandom;
      model(we, sz, u, a, wd, erd, ef, elat);
      run($sformatf("rnd%0d", k), we, sz, u, a, wd, erd, ef, elat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
